// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin owner selection for the shared LED bank.
// Each grant is held for at least HOLD_CYCLES cycles. LED shows the owner's
// live pattern through one register stage.
// Optional macro LED_GAP_EN: every handoff and every release passes through
// a blank GAP state that lasts GAP_CYCLES cycles.
module led_bank_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] pat,
  output logic [NREQ-1:0]   grant,
  output logic [3:0]        LED,
  output logic              busy
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam int LW = $clog2(NREQ);
  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0]   LAST_IDX  = LW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

  // Catch illegal parameter values while the design is being elaborated
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("led_bank_arbiter: NREQ must be 2..8");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("led_bank_arbiter: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("led_bank_arbiter: GAP_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [LW-1:0]   last, last_n;
  logic [NREQ-1:0] grant_n;
  logic [3:0]      led_n;
  logic            busy_n;
  logic [3:0]      pat_arr [NREQ];
  logic [LW:0]     rr_all;
  logic [LW:0]     rr_other;
  logic            hold_done;

`ifdef LED_GAP_EN
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  logic [GW-1:0] gap_cnt, gap_cnt_n;
`endif

  // Pick the first set mask bit after 'from', wrapping modulo NREQ.
  // Bit LW of the result flags that something was found.
  // The index sits in the low LW bits.
  function automatic logic [LW:0] rr_pick(input logic [NREQ-1:0] mask,
                                          input logic [LW-1:0]   from);
    logic [LW-1:0] idx;
    logic          found;
    logic [LW-1:0] win;
    idx   = from;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (!found && mask[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  // Split the packed pattern bus into one 4-bit entry per requester
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      pat_arr[i] = pat[4*i +: 4];
    end
  end

  // Round-robin candidates.
  // rr_all considers every requester; rr_other excludes the current owner.
  always_comb begin
    rr_all    = rr_pick(req, last);
    rr_other  = rr_pick(req & ~grant, last);
    hold_done = (cnt == HOLD_LAST);
  end

  // State, owner pointer and counters, with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      last  <= LAST_IDX;
      grant <= '0;
      LED   <= '0;
      busy  <= 1'b0;
`ifdef LED_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      last  <= last_n;
      grant <= grant_n;
      LED   <= led_n;
      busy  <= busy_n;
`ifdef LED_GAP_EN
      gap_cnt <= gap_cnt_n;
`endif
    end
  end

  // Next-state logic: arbitration, hold timing and handoff/release decisions
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
`ifdef LED_GAP_EN
    gap_cnt_n = gap_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (rr_all[LW]) begin
          state_n = S_GRANT;
          last_n  = rr_all[LW-1:0];
          cnt_n   = '0;
        end
      end
      S_GRANT: begin
        if (!hold_done) begin
          cnt_n = cnt + 1'b1;
        end else if (rr_other[LW]) begin
`ifdef LED_GAP_EN
          state_n   = S_GAP;
          gap_cnt_n = '0;
`else
          state_n = S_GRANT;
          last_n  = rr_other[LW-1:0];
          cnt_n   = '0;
`endif
        end else if (!req[last]) begin
`ifdef LED_GAP_EN
          state_n   = S_GAP;
          gap_cnt_n = '0;
`else
          state_n = S_IDLE;
`endif
        end
      end
      S_GAP: begin
`ifdef LED_GAP_EN
        if (gap_cnt == GAP_LAST) begin
          if (rr_all[LW]) begin
            state_n = S_GRANT;
            last_n  = rr_all[LW-1:0];
            cnt_n   = '0;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
`else
        state_n = S_IDLE;
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output logic: derive the next registered outputs from the next state
  always_comb begin
    grant_n = '0;
    led_n   = '0;
    busy_n  = (state_n != S_IDLE);
    if (state_n == S_GRANT) begin
      grant_n = ONE_HOT0 << last_n;
      led_n   = pat_arr[last_n];
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb_led_bank_arbiter: directed scenarios with literal expectations.
// These are followed by a randomized run.
// Both parts are checked every cycle against an owner/hold/gap reference model.
module tb_led_bank_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
`ifdef LED_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [15:0] pat = 16'h0000;
  logic [3:0]  grant;
  logic [3:0]  LED;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  led_bank_arbiter #(
    .NREQ(NREQ),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES(GAP)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .req(req),
    .pat(pat),
    .grant(grant),
    .LED(LED),
    .busy(busy)
  );

  // Reference model: current owner (-1 = none), cycles held so far,
  // remaining gap cycles, and the last winner for round robin
  bit         model_ok = 1'b0;
  int         m_owner  = -1;
  int         m_held   = 0;
  int         m_gap    = 0;
  int         m_last   = NREQ - 1;
  logic [3:0] m_led    = 4'h0;

  function automatic int pick(input logic [3:0] m, input int from);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (from + k) % NREQ;
      if (m[2'(i)]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] pat_of(input logic [15:0] p, input int i);
    return p[4*i +: 4];
  endfunction

  // Advance the model on every rising edge using the inputs held across it
  always @(posedge CLK) begin
    int w;
    if (RST) begin
      m_owner  = -1;
      m_held   = 0;
      m_gap    = 0;
      m_last   = NREQ - 1;
      m_led    = 4'h0;
      model_ok = 1'b1;
    end else if (m_owner >= 0) begin
      if (m_held < HOLD) begin
        m_held++;
        m_led = pat_of(pat, m_owner);
      end else begin
        w = pick(req & ~(4'b0001 << m_owner), m_last);
        if (w >= 0 && !GAP_ON) begin
          m_owner = w;
          m_last  = w;
          m_held  = 1;
          m_led   = pat_of(pat, w);
        end else if (w < 0 && req[2'(m_owner)]) begin
          m_led = pat_of(pat, m_owner);
        end else if (GAP_ON) begin
          m_owner = -1;
          m_gap   = GAP;
          m_led   = 4'h0;
        end else begin
          m_owner = -1;
          m_led   = 4'h0;
        end
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap = 0;
      w = pick(req, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_held  = 1;
        m_led   = pat_of(pat, w);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] act,
                             input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT with the model on every falling edge once reset has been seen
  always @(negedge CLK) begin
    if (model_ok) begin
      checkOutput("model_grant", grant,
                  (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000);
      checkOutput("model_led", LED, m_led);
      checkOutput("model_busy", {3'b000, busy},
                  {3'b000, (m_owner >= 0) || (m_gap > 0)});
    end
  end

  task automatic applyStimulus(input logic rst, input logic [3:0] r,
                               input logic [15:0] p);
    RST = rst;
    req = r;
    pat = p;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0] seq_grant [13];
  logic [3:0] seq_led   [13];

  initial begin
    // Scenario 1: reset held with every requester asking; requester 0 wins first
    applyStimulus(1'b1, 4'b1111, 16'h4321);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("rst_grant", grant, 4'b0000);
      checkOutput("rst_led", LED, 4'h0);
      checkOutput("rst_busy", {3'b000, busy}, 4'h0);
    end
    applyStimulus(1'b0, 4'b1111, 16'h4321);
    tick();
    checkOutput("first_grant", grant, 4'b0001);
    checkOutput("first_led", LED, 4'h1);

    // Scenario 2: short request still gets the full hold, then release
    applyStimulus(1'b1, 4'b0000, 16'h0000);
    tick();
    applyStimulus(1'b0, 4'b0100, 16'h0A00);
    tick();
    checkOutput("short_grant", grant, 4'b0100);
    checkOutput("short_led", LED, 4'hA);
    applyStimulus(1'b0, 4'b0000, 16'h0A00);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("short_hold_grant", grant, 4'b0100);
      checkOutput("short_hold_led", LED, 4'hA);
    end
    tick();
    checkOutput("release_grant", grant, 4'b0000);
    checkOutput("release_led", LED, 4'h0);
    checkOutput("release_busy", {3'b000, busy}, GAP_ON ? 4'h1 : 4'h0);

    // Scenario 3 / 6: two requesters held; alternate with or without blank gaps
    applyStimulus(1'b1, 4'b0000, 16'h0000);
    tick();
`ifdef LED_GAP_EN
    applyStimulus(1'b0, 4'b0011, 16'h0053);
    seq_grant = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                  4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0001};
    seq_led   = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h0, 4'h0,
                  4'h5, 4'h5, 4'h5, 4'h5, 4'h0, 4'h0, 4'h3};
    for (int i = 0; i < 13; i++) begin
      tick();
      checkOutput("gap_seq_grant", grant, seq_grant[i]);
      checkOutput("gap_seq_led", LED, seq_led[i]);
      checkOutput("gap_seq_busy", {3'b000, busy}, 4'h1);
    end
`else
    applyStimulus(1'b0, 4'b0101, 16'h0C03);
    seq_grant = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100,
                  4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100};
    seq_led   = '{4'h3, 4'h3, 4'h3, 4'h3, 4'hC, 4'hC,
                  4'hC, 4'hC, 4'h3, 4'h3, 4'h3, 4'h3, 4'hC};
    for (int i = 0; i < 13; i++) begin
      tick();
      checkOutput("rr_seq_grant", grant, seq_grant[i]);
      checkOutput("rr_seq_led", LED, seq_led[i]);
      checkOutput("rr_seq_busy", {3'b000, busy}, 4'h1);
    end
`endif

    // Scenario 4: lone requester keeps the bank; the live pattern change shows one cycle later
    applyStimulus(1'b1, 4'b0000, 16'h0000);
    tick();
    applyStimulus(1'b0, 4'b1000, 16'h5000);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) pat = 16'h6000;
      tick();
      checkOutput("lone_grant", grant, 4'b1000);
      checkOutput("lone_led", LED, (i >= 10) ? 4'h6 : 4'h5);
    end

    // Scenario 5: reset in the middle of a hold aborts it and resets the pointer
    applyStimulus(1'b1, 4'b0000, 16'h0000);
    tick();
    applyStimulus(1'b0, 4'b0001, 16'h00E7);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("mid_grant", grant, 4'b0001);
    applyStimulus(1'b1, 4'b0010, 16'h00E7);
    tick();
    checkOutput("abort_grant", grant, 4'b0000);
    checkOutput("abort_led", LED, 4'h0);
    checkOutput("abort_busy", {3'b000, busy}, 4'h0);
    applyStimulus(1'b0, 4'b0010, 16'h00E7);
    tick();
    checkOutput("after_abort_grant", grant, 4'b0010);
    checkOutput("after_abort_led", LED, 4'hE);

    // Randomized traffic: slowly changing requests, live patterns, rare resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) req = 4'($urandom);
      if ($urandom_range(0, 7) == 0) req = 4'b0000;
      pat = 16'($urandom);
      RST = ($urandom_range(0, 199) == 0);
      tick();
    end

    applyStimulus(1'b0, 4'b0000, 16'h0000);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
